// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Reads a truth table back out of a combinational circuit. Every input vector
//   is driven in turn, held for SETTLE idle cycles, and then the single output
//   is sampled into the table. The finished table is offered on a valid/ready
//   port. tt[i] is the response to vector i, so a table written as 16'h429B
//   reads back as 16'h429B.
//
//   Parameters
//     N_IN    number of circuit inputs (1..6); the table is 2**N_IN bits wide
//     SETTLE  idle cycles a vector is held before it is sampled (0..255)
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-high reset; overrides everything and
//                discards any partial sweep
//     start      request a sweep; taken in IDLE, or in DONE together with tt_ready
//     busy       sweep in progress
//     dut_in     vector driven to the circuit (0 whenever no sweep is running)
//     dut_out    circuit response to dut_in
//     tt_valid   captured table available
//     tt_ready   consumer takes the table when tt_valid & tt_ready
//     tt         captured table
//
//   Optional feature, macro TT_EXPECT_EN:
//     tt_expect  golden table, captured when a sweep is accepted
//     tt_match   valid with tt_valid; 1 when tt equals the captured golden table
//   Without the macro these ports and the compare logic are absent.

module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   tt_valid,
  input  logic                   tt_ready,
`ifdef TT_EXPECT_EN
  input  logic [(1<<N_IN)-1:0]   tt_expect,
  output logic                   tt_match,
`endif
  output logic [(1<<N_IN)-1:0]   tt
);

  localparam int TW = 1 << N_IN;
  // Settle counter only has to reach SETTLE; keep at least one bit so
  // SETTLE=0 still builds.
  localparam int WW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [WW-1:0]   SETTLE_W = WW'(SETTLE);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [WW-1:0]   wcnt;

`ifdef TT_EXPECT_EN
  logic [TW-1:0]   expect_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      wcnt  <= '0;
      tt    <= '0;
`ifdef TT_EXPECT_EN
      expect_q <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SWEEP;
            idx   <= '0;
            wcnt  <= '0;
            tt    <= '0;
`ifdef TT_EXPECT_EN
            expect_q <= tt_expect;
`endif
          end
        end
        S_SWEEP: begin
          if (wcnt != SETTLE_W) begin
            wcnt <= wcnt + WW'(1);
          end else begin
            tt[idx] <= dut_out;
            wcnt    <= '0;
            // Leave idx at the last vector rather than wrapping, so nothing
            // can ever alias back onto tt[0].
            if (idx == IDX_LAST) state <= S_DONE;
            else                 idx   <= idx + N_IN'(1);
          end
        end
        S_DONE: begin
          if (tt_ready) begin
            if (start) begin
              // Back-to-back sweep: hand off and restart in the same edge.
              state <= S_SWEEP;
              idx   <= '0;
              wcnt  <= '0;
              tt    <= '0;
`ifdef TT_EXPECT_EN
              expect_q <= tt_expect;
`endif
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state == S_SWEEP);
  assign tt_valid = (state == S_DONE);
  assign dut_in   = (state == S_SWEEP) ? idx : '0;

`ifdef TT_EXPECT_EN
  assign tt_match = (state == S_DONE) && (tt == expect_q);
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (N_IN=4, SETTLE=2). The circuit under test is
// modelled as a lookup of a selectable 16-bit table; every table a sweep is
// started with is pushed to a scoreboard queue and popped at the handshake.
module tb_truth_table_sweeper;

  localparam int N_IN = 4;
  localparam int SETTLE = 2;
  localparam int TW = 1 << N_IN;
  localparam int LAT = TW * (SETTLE + 1);

  logic            clk = 1'b0;
  logic            rst, start, tt_ready;
  logic            busy, tt_valid, dut_out;
  logic [N_IN-1:0] dut_in;
  logic [TW-1:0]   tt;
  logic [TW-1:0]   cur_tab;
`ifdef TT_EXPECT_EN
  logic [TW-1:0]   tt_expect;
  logic            tt_match;
`endif

  int checks = 0;
  int errors = 0;
  logic [TW-1:0] sb_q[$];

  always #5 clk = ~clk;

  // Combinational circuit under test.
  assign dut_out = cur_tab[dut_in];

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .dut_in(dut_in),
    .dut_out(dut_out), .tt_valid(tt_valid), .tt_ready(tt_ready),
`ifdef TT_EXPECT_EN
    .tt_expect(tt_expect), .tt_match(tt_match),
`endif
    .tt(tt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive start for one cycle with the circuit set to tab; returns on the
  // negedge just after the accepting edge.
  task automatic kick(input logic [TW-1:0] tab);
    cur_tab = tab;
    sb_q.push_back(tab);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge just after the accepting edge; follows the vector
  // sequence and the completion latency.
  task automatic follow(input string tag);
    bit seq_ok = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      if (dut_in !== N_IN'(k / (SETTLE + 1)) || busy !== 1'b1 || tt_valid !== 1'b0)
        seq_ok = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_seq"}, 32'(seq_ok), 32'd1);
    chk({tag, "_valid_at_lat"}, 32'(tt_valid), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  // Compare the offered table against the scoreboard; if ack, take it.
  task automatic check_table(input string tag);
    logic [TW-1:0] exp_tab;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    exp_tab = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk({tag, "_tt"}, 32'(tt), 32'(exp_tab));
`ifdef TT_EXPECT_EN
    chk({tag, "_match"}, 32'(tt_match), 32'(exp_tab == tt_expect));
`endif
  endtask

  task automatic drain(input string tag);
    check_table(tag);
    tt_ready = 1'b1;
    @(negedge clk);
    tt_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(tt_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    bit seen;
    logic [TW-1:0] held;
    rst = 1'b1; start = 1'b0; tt_ready = 1'b0; cur_tab = 16'h429B;
`ifdef TT_EXPECT_EN
    tt_expect = 16'h429B;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(tt_valid), 32'd0);
    chk("rst_tt", 32'(tt), 32'd0);
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reference table, then the constant-ish circuits.
    kick(16'h429B); follow("t429b"); drain("t429b");
    kick(16'h8000); follow("and4");  drain("and4");
    kick(16'h0000); follow("zero");  drain("zero");
    kick(16'hFFFF); follow("ones");  drain("ones");

    // Consumer stalls 20 cycles; a start in the middle must be ignored.
    kick(16'h429B); follow("stall");
    held = tt; ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      start = (k == 10);
      if (tt_valid !== 1'b1 || tt !== held || dut_in !== '0 || busy !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall_stable", 32'(ok), 32'd1);
    drain("stall");
    chk("stall_no_restart", 32'(busy), 32'd0);

    // Reset in the middle of vector 7 discards the sweep.
    kick(16'h429B);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (dut_in == 4'd7) seen = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reached_v7", 32'(seen), 32'd1);
    chk("abort_partial_nonzero", 32'(tt != '0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tt", 32'(tt), 32'd0);
    chk("abort_dut_in", 32'(dut_in), 32'd0);
    chk("abort_valid", 32'(tt_valid), 32'd0);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    @(negedge clk);
    kick(16'h429B); follow("post_rst"); drain("post_rst");

    // Back-to-back: accept and restart in the same DONE cycle.
    kick(16'h429B); follow("b2b_a");
    check_table("b2b_a");
    cur_tab = 16'h8000;
    sb_q.push_back(16'h8000);
    tt_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    tt_ready = 1'b0; start = 1'b0;
    chk("b2b_valid", 32'(tt_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_dut_in", 32'(dut_in), 32'd0);
    chk("b2b_tt_cleared", 32'(tt), 32'd0);
    follow("b2b_b"); drain("b2b_b");

    chk("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
